// File: rtl/mux_operand_arbiter_pkg.sv
// Shared definitions for the operand arbiter.
// Provides the source encoding carried on out_src/ch and the arbiter FSM state type.
package mux_operand_arbiter_pkg;

  // Source identifiers: also the MUX select value that routes that requester.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Arbiter states: free arbitration, or grant held for a locked burst.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/MUX_2_32bit.sv
// Two-input word multiplexer feeding the arbiter output register.
// Ports:
//   ch  - select: 0 routes ina, 1 routes inb
//   ina - word from requester A
//   inb - word from requester B
//   out - selected word
module MUX_2_32bit #(
  parameter int W = 32
) (
  input  logic         ch,
  input  logic [W-1:0] ina,
  input  logic [W-1:0] inb,
  output logic [W-1:0] out
);

  // Pure combinational select; no storage here.
  assign out = ch ? inb : ina;

endmodule

// File: rtl/mux_operand_arbiter.sv
// Shares one operand path between requesters A and B using valid/ready handshakes.
// The grant drives the MUX select, the chosen word is registered into a single
// output stage and presented downstream with valid/ready. Ties alternate
// round-robin; a requester may lock the grant for up to BURST_MAX beats.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   a_valid/a_data/a_lock       - requester A word, valid and lock request
//   a_ready                     - A word accepted this cycle
//   b_valid/b_data/b_lock       - requester B word, valid and lock request
//   b_ready                     - B word accepted this cycle
//   out_valid/out_data/out_src  - registered word, its valid and its source
//   out_ready                   - downstream consumes out_data this cycle
//   ch                          - MUX select, equal to the current grant
module mux_operand_arbiter
  import mux_operand_arbiter_pkg::*;
#(
  parameter int W         = 32,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_lock,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_lock,
  output logic         b_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready,
  output logic         ch
);

  localparam int CW = $clog2(BURST_MAX + 1);
  // beat_cnt + 1 < BURST_MAX is the same test as beat_cnt < BURST_MAX - 1.
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
  localparam bit CAN_LOCK = (BURST_MAX > 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_src_q, out_src_d;

  logic          grant;
  logic          grant_lock;
  logic          accept;
  logic          hs;
  logic [W-1:0]  mux_out;

  // Output stage can take a new word when empty or being drained this cycle.
  assign accept = !out_valid_q || out_ready;

  // Grant selection. In a lock the owner keeps the grant even while idle, so the
  // other requester cannot slip in mid-burst. With nobody valid the select
  // simply parks on the last winner.
  always_comb begin
    grant = last_q;
    case (state_q)
      ST_LOCK_A: grant = SRC_A;
      ST_LOCK_B: grant = SRC_B;
      default: begin
        if (a_valid && b_valid) grant = ~last_q;
        else if (a_valid)       grant = SRC_A;
        else if (b_valid)       grant = SRC_B;
      end
    endcase
  end

  assign ch         = grant;
  assign grant_lock = (grant == SRC_B) ? b_lock : a_lock;
  assign a_ready    = !rst && accept && a_valid && (grant == SRC_A);
  assign b_ready    = !rst && accept && b_valid && (grant == SRC_B);
  assign hs         = a_ready || b_ready;

  MUX_2_32bit #(.W(W)) u_mux (
    .ch  (grant),
    .ina (a_data),
    .inb (b_data),
    .out (mux_out)
  );

  // Next-state for the output register, round-robin pointer and burst FSM.
  // Everything except draining the output only moves on an accepted beat.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    if (hs) begin
      out_data_d  = mux_out;
      out_src_d   = grant;
      out_valid_d = 1'b1;
      last_d      = grant;

      if (state_q == ST_IDLE) begin
        if (grant_lock && CAN_LOCK) begin
          state_d    = (grant == SRC_B) ? ST_LOCK_B : ST_LOCK_A;
          beat_cnt_d = CW'(1);
        end
      end else if (grant_lock && (beat_cnt_q < CNT_LAST)) begin
        beat_cnt_d = beat_cnt_q + CW'(1);
      end else begin
        // Burst ends on a released lock or on reaching the cap.
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= SRC_B;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_A;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_operand_arbiter.sv
// Scoreboard bench for mux_operand_arbiter: directed streams push hand-computed
// expected words; a monitor pops and compares whenever a word is consumed and
// checks the one-cycle handshake-to-output latency.
module tb_mux_operand_arbiter;

  typedef struct {
    logic        src;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_lock, a_ready;
  logic [31:0] a_data;
  logic        b_valid, b_lock, b_ready;
  logic [31:0] b_data;
  logic        out_valid, out_src, out_ready, ch;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t        exp_q[$];
  int          hs_q[$];
  logic [31:0] a_words[$];
  logic        a_locks[$];
  logic [31:0] b_words[$];
  logic        b_locks[$];

  logic prev_valid = 1'b0;
  logic prev_cons  = 1'b0;
  logic pend_hs    = 1'b0;

  mux_operand_arbiter #(.W(32), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_lock    (a_lock),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_lock    (b_lock),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .ch        (ch)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic src, input logic [31:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Records handshakes so the monitor can check the output appears the next cycle.
  always begin
    @(negedge clk);
    #3;
    pend_hs = !rst && ((a_valid && a_ready) || (b_valid && b_ready));
    @(posedge clk);
    if (pend_hs) hs_q.push_back(cyc);
    cyc++;
  end

  // Monitor: checks latency on each newly presented word and pops the
  // scoreboard whenever downstream consumes a word.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_valid = 1'b0;
      prev_cons  = 1'b0;
    end else begin
      if (out_valid && (!prev_valid || prev_cons)) begin
        if (hs_q.size() == 0) begin
          checkOutput("latency_no_handshake", 32'd1, 32'd0);
        end else begin
          checkOutput("latency_cycle", cyc, hs_q.pop_front() + 1);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", out_data, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_src", 32'(out_src), 32'(e.src));
        end
      end
      prev_valid = out_valid;
      prev_cons  = out_valid && out_ready;
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_lock    = 1'b0;
    b_lock    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hs_q.delete();
  endtask

  // Drives the queued A/B words, advancing each stream on its handshake.
  task automatic applyStimulus();
    int  budget = 0;
    logic fa, fb;
    while ((a_words.size() > 0 || b_words.size() > 0) && budget < 200) begin
      @(negedge clk);
      budget++;
      a_valid = (a_words.size() > 0);
      a_data  = a_valid ? a_words[0] : 32'd0;
      a_lock  = a_valid ? a_locks[0] : 1'b0;
      b_valid = (b_words.size() > 0);
      b_data  = b_valid ? b_words[0] : 32'd0;
      b_lock  = b_valid ? b_locks[0] : 1'b0;
      #1;
      checkOutput("ready_exclusive", 32'(a_ready & b_ready), 32'd0);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk);
      if (fa) begin void'(a_words.pop_front()); void'(a_locks.pop_front()); end
      if (fb) begin void'(b_words.pop_front()); void'(b_locks.pop_front()); end
    end
    if (a_words.size() > 0 || b_words.size() > 0) begin
      checkOutput("stimulus_timeout", 32'(a_words.size() + b_words.size()), 32'd0);
      a_words.delete(); a_locks.delete(); b_words.delete(); b_locks.delete();
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_lock  = 1'b0;
    b_lock  = 1'b0;
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (exp_q.size() > 0 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    #4;
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 32'd7;
    b_data    = 32'd9;
    a_lock    = 1'b0;
    b_lock    = 1'b0;
    out_ready = 1'b0;

    // Reset held with both requesters valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
    checkOutput("reset_b_ready", 32'(b_ready), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_src", 32'(out_src), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;

    // Alternation with both always valid, A wins the first tie.
    $display("[TB] alternation");
    out_ready = 1'b1;
    a_words = '{32'd31, 32'd32, 32'd33}; a_locks = '{1'b0, 1'b0, 1'b0};
    b_words = '{32'd55, 32'd56, 32'd57}; b_locks = '{1'b0, 1'b0, 1'b0};
    pushExp(1'b0, 32'd31); pushExp(1'b1, 32'd55);
    pushExp(1'b0, 32'd32); pushExp(1'b1, 32'd56);
    pushExp(1'b0, 32'd33); pushExp(1'b1, 32'd57);
    applyStimulus();
    waitDrain();

    // Stall: output holds 31 for three cycles, nobody readied.
    $display("[TB] stall");
    doReset();
    pushExp(1'b0, 32'd31); pushExp(1'b1, 32'd55); pushExp(1'b0, 32'd32);
    a_valid = 1'b1; a_data = 32'd31; a_lock = 1'b0;
    #1;
    checkOutput("stall_first_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_data  = 32'd32;
    b_valid = 1'b1; b_data = 32'd55; b_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_out_data", out_data, 32'd31);
      checkOutput("stall_a_ready", 32'(a_ready), 32'd0);
      checkOutput("stall_b_ready", 32'(b_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_b_ready", 32'(b_ready), 32'd1);
    checkOutput("release_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    checkOutput("release_next_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    waitDrain();

    // Burst cap of four locked beats, then B gets its turn.
    $display("[TB] burst cap");
    doReset();
    out_ready = 1'b1;
    a_words = '{32'd101, 32'd102, 32'd103, 32'd104, 32'd105, 32'd106};
    a_locks = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    b_words = '{32'd55}; b_locks = '{1'b0};
    pushExp(1'b0, 32'd101); pushExp(1'b0, 32'd102);
    pushExp(1'b0, 32'd103); pushExp(1'b0, 32'd104);
    pushExp(1'b1, 32'd55);
    pushExp(1'b0, 32'd105); pushExp(1'b0, 32'd106);
    applyStimulus();
    waitDrain();

    // Early unlock: lock released on beat 2, so B wins the following tie.
    $display("[TB] early unlock");
    doReset();
    out_ready = 1'b1;
    a_words = '{32'd31, 32'd32, 32'd33}; a_locks = '{1'b1, 1'b0, 1'b0};
    b_words = '{32'd55}; b_locks = '{1'b0};
    pushExp(1'b0, 32'd31); pushExp(1'b0, 32'd32);
    pushExp(1'b1, 32'd55); pushExp(1'b0, 32'd33);
    applyStimulus();
    waitDrain();

    // Reset in the middle of a locked A burst; the in-flight word is dropped.
    $display("[TB] reset mid-burst");
    doReset();
    out_ready = 1'b1;
    pushExp(1'b0, 32'd31);
    a_valid = 1'b1; a_data = 32'd31; a_lock = 1'b1;
    b_valid = 1'b1; b_data = 32'd55; b_lock = 1'b0;
    #1;
    checkOutput("burst_beat1_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_data = 32'd32;
    #1;
    checkOutput("burst_beat2_a_ready", 32'(a_ready), 32'd1);
    checkOutput("burst_beat2_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b0;
    a_data    = 32'd33;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midburst_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midburst_reset_out_data", out_data, 32'd0);
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_lock  = 1'b0;
    hs_q.delete();
    out_ready = 1'b1;
    a_words = '{32'd40}; a_locks = '{1'b0};
    b_words = '{32'd60}; b_locks = '{1'b0};
    pushExp(1'b0, 32'd40); pushExp(1'b1, 32'd60);
    applyStimulus();
    waitDrain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
